// File: rtl/myproject_mul_rr_sched.sv
// Round-robin scheduler sharing one pipelined 24x18 multiplier among NUM_REQ requesters.
// Optional per-requester handshake counters (grant_cnt) are built when MUL_RR_SCHED_STATS_EN is defined.
module myproject_mul_rr_sched #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int DIN0_WIDTH  = 24,
  parameter int DIN1_WIDTH  = 18,
  parameter int DOUT_WIDTH  = 37,
  parameter int MUL_LATENCY = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ce,
  input  logic                          flush,
  output logic                          flush_done,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1,
  output logic                          mul_ce,
  output logic [DIN0_WIDTH-1:0]         mul_din0,
  output logic [DIN1_WIDTH-1:0]         mul_din1,
  input  logic [DOUT_WIDTH-1:0]         mul_dout,
  output logic [NUM_REQ-1:0]            res_valid,
  output logic [DOUT_WIDTH-1:0]         res_data
`ifdef MUL_RR_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt
`endif
);

  // state    | meaning
  // ST_RUN   | granting requesters round-robin
  // ST_DRAIN | no grants; waiting for in-flight products to be delivered
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]            state;
  logic [ID_W-1:0]       rr_ptr;
  logic                  grant_en;
  logic                  hs;
  logic                  hi_found, lo_found, gnt_found;
  logic [ID_W-1:0]       hi_id, lo_id, gnt_id;
  logic [DIN0_WIDTH-1:0] sel_din0;
  logic [DIN1_WIDTH-1:0] sel_din1;
  logic [NUM_REQ-1:0]    tail_onehot;

  // Stage 0 lines up with mul_din0/1; stage MUL_LATENCY lines up with mul_dout.
  logic [MUL_LATENCY:0]  tag_vld;
  logic [ID_W-1:0]       tag_id [MUL_LATENCY+1];

  assign mul_ce   = ce;
  assign grant_en = (state == ST_RUN) && ce && !reset && !flush;
  assign hs       = grant_en && gnt_found;

  // Lowest valid index at or above the pointer wins; otherwise wrap to lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_id    = ID_W'(i);
        if (ID_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(i);
        end
      end
    end
    gnt_found = hi_found || lo_found;
    gnt_id    = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    sel_din0  = '0;
    sel_din1  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        sel_din0     = req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
        sel_din1     = req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
        req_ready[i] = hs;
      end
    end
  end

  always_comb begin
    tail_onehot = '0;
    tail_onehot[tag_id[MUL_LATENCY]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      rr_ptr     <= '0;
      mul_din0   <= '0;
      mul_din1   <= '0;
      tag_vld    <= '0;
      res_valid  <= '0;
      res_data   <= '0;
      flush_done <= 1'b0;
      for (int i = 0; i <= MUL_LATENCY; i++) tag_id[i] <= '0;
    end else if (ce) begin
      if (hs) begin
        mul_din0 <= sel_din0;
        mul_din1 <= sel_din1;
        rr_ptr   <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      tag_vld   <= {tag_vld[MUL_LATENCY-1:0], hs};
      tag_id[0] <= gnt_id;
      for (int i = 1; i <= MUL_LATENCY; i++) tag_id[i] <= tag_id[i-1];

      res_valid <= tag_vld[MUL_LATENCY] ? tail_onehot : '0;
      if (tag_vld[MUL_LATENCY]) res_data <= mul_dout;

      flush_done <= 1'b0;
      case (state)
        ST_RUN: begin
          if (flush) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((tag_vld == '0) && (res_valid == '0)) begin
            state      <= ST_RUN;
            flush_done <= 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef MUL_RR_SCHED_STATS_EN
  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_stats
      logic [15:0] cnt;
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt <= '0;
        end else if (ce && req_valid[g] && req_ready[g] && (cnt != 16'hFFFF)) begin
          cnt <= cnt + 16'd1;
        end
      end
      assign grant_cnt[g*16 +: 16] = cnt;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_myproject_mul_rr_sched.sv
// Scoreboard bench for myproject_mul_rr_sched: reference grant/drain model plus an external multiplier model.
module tb_myproject_mul_rr_sched;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 24;
  localparam int BW = 18;
  localparam int DW = 37;
  localparam int L  = 3;

  logic clk = 1'b0;
  logic reset, ce, flush, flush_done, mul_ce;
  logic [N-1:0]    req_valid, req_ready, res_valid;
  logic [N*AW-1:0] req_din0;
  logic [N*BW-1:0] req_din1;
  logic [AW-1:0]   mul_din0;
  logic [BW-1:0]   mul_din1;
  logic [DW-1:0]   mul_dout, res_data;
`ifdef MUL_RR_SCHED_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  myproject_mul_rr_sched dut (
    .clk(clk), .reset(reset), .ce(ce), .flush(flush), .flush_done(flush_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_din0(req_din0), .req_din1(req_din1),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .res_valid(res_valid), .res_data(res_data)
`ifdef MUL_RR_SCHED_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  // External multiplier: L ce-qualified stages, product kept to DW bits.
  logic [DW-1:0] mpipe [L];
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= DW'(64'(mul_din0) * 64'(mul_din1));
      for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_dout = mpipe[L-1];

  logic [AW-1:0] op_a [N];
  logic [BW-1:0] op_b [N];
  bit   [N-1:0]  rv;
  always_comb begin
    req_valid = rv;
    for (int i = 0; i < N; i++) begin
      req_din0[i*AW +: AW] = op_a[i];
      req_din1[i*BW +: BW] = op_b[i];
    end
  end

  typedef struct {int id; longint unsigned data; longint unsigned due;} exp_t;
  exp_t sbq[$];

  int n_total = 0;
  int n_pass  = 0;
  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
  endtask

  longint unsigned ce_edges = 0;
  bit last_ce = 1'b0;
  always @(posedge clk) begin
    if (ce) ce_edges++;
    last_ce = ce;
  end

  // Monitor: one result per ce-qualified edge that presents a strobe.
  bit res_shown = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (last_ce) begin
      res_shown = 1'b0;
      if (res_valid != '0) begin
        res_shown = 1'b1;
        if (sbq.size() == 0) begin
          chk("unexpected_result", longint'(res_valid), 0);
        end else begin
          e = sbq.pop_front();
          chk("res_valid", longint'(res_valid), longint'(1) << e.id);
          chk("res_data", res_data, e.data);
          chk("res_latency", ce_edges, e.due);
        end
      end
    end
  end

  // Reference model state.
  int m_ptr   = 0;
  bit m_drain = 1'b0;
  bit exp_fd  = 1'b0;

  task automatic new_op(input int i, input int pct);
    rv[i]   = ($urandom_range(99) < pct);
    op_a[i] = AW'($urandom);
    op_b[i] = BW'($urandom);
  endtask

  task automatic step(input bit c, input bit f, input bit r, input int refill_pct);
    int g;
    int idx;
    bit new_fd;
    @(negedge clk);
    #2;
    chk("flush_done", flush_done, exp_fd);
    ce = c; flush = f; reset = r;
    #1;
    g = -1;
    if (!m_drain && c && !r && !f) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && rv[idx]) g = idx;
      end
    end
    chk("req_ready", req_ready, (g >= 0) ? (longint'(1) << g) : 0);
    if (r) begin
      sbq.delete();
      m_ptr = 0; m_drain = 1'b0; exp_fd = 1'b0;
    end else if (c) begin
      new_fd = 1'b0;
      if (g >= 0) begin
        sbq.push_back('{g, (64'(op_a[g]) * 64'(op_b[g])) & ((64'd1 << DW) - 1), ce_edges + L + 2});
        m_ptr = (g + 1) % N;
      end
      if (m_drain) begin
        if (sbq.size() == 0 && !res_shown) begin
          m_drain = 1'b0;
          new_fd  = 1'b1;
        end
      end else if (f) begin
        m_drain = 1'b1;
      end
      exp_fd = new_fd;
    end
    @(posedge clk);
    #1;
    if (g >= 0) new_op(g, refill_pct);
  endtask

  initial begin
    for (int i = 0; i < L; i++) mpipe[i] = '0;
    for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
    rv = '0; reset = 1'b1; ce = 1'b1; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_mul_din0", mul_din0, 0);
    chk("rst_mul_din1", mul_din1, 0);
    chk("rst_flush_done", flush_done, 0);
    step(1, 0, 0, 0);

    // Single op from requester 0, then max-value operands from requester 1.
    rv[0] = 1'b1; op_a[0] = 24'h000003; op_b[0] = 18'h00005;
    repeat (8) step(1, 0, 0, 0);
    rv[1] = 1'b1; op_a[1] = 24'hFFFFFF; op_b[1] = 18'h3FFFF;
    repeat (8) step(1, 0, 0, 0);

    // All requesters continuously valid.
    for (int i = 0; i < N; i++) new_op(i, 100);
    repeat (8) step(1, 0, 0, 100);
    rv = '0;
    repeat (8) step(1, 0, 0, 0);

    // Two ops in flight, then a 3-cycle ce stall.
    new_op(0, 100); new_op(1, 100);
    repeat (2) step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (8) step(1, 0, 0, 0);

    // Flush with ops in flight while requests stay asserted.
    for (int i = 0; i < N; i++) new_op(i, 100);
    repeat (3) step(1, 0, 0, 100);
    step(1, 1, 0, 100);
    repeat (12) step(1, 0, 0, 100);
    rv = '0;
    repeat (8) step(1, 0, 0, 0);
    // Flush with an empty pipeline.
    step(1, 1, 0, 0);
    repeat (4) step(1, 0, 0, 0);

    // Reset two cycles after an issue; the op must never surface.
    new_op(2, 100);
    step(1, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    rv = '1;
    repeat (8) step(1, 0, 0, 0);
    rv = '0;
    repeat (8) step(1, 0, 0, 0);

    // Randomized traffic with stalls, flushes and occasional resets.
    for (int i = 0; i < N; i++) new_op(i, 60);
    for (int n = 0; n < 3000; n++) begin
      bit c, f, r;
      r = ($urandom_range(999) < 5);
      c = r ? 1'b1 : ($urandom_range(99) < 90);
      f = !r && c && ($urandom_range(99) < 2);
      step(c, f, r, 60);
      for (int i = 0; i < N; i++) if (!rv[i] && $urandom_range(99) < 30) new_op(i, 100);
    end

    rv = '0;
    repeat (20) step(1, 0, 0, 0);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
